// File: rtl/ft245_tx_buffer.sv
// ============================================================================
// Module      : ft245_tx_buffer
// Description : Show-ahead byte FIFO feeding the FT245 sync-FIFO writer, with
//               an idle-flush pulse (flush_n) once a drained burst goes quiet.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ft245_tx_buffer #(
   parameter int DEPTH_LOG2 = 4,
   parameter int FLUSH_IDLE = 255
) (
   input  logic                  clock_60mhz,
   input  logic                  reset_n,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [7:0]            out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  flush_n,
   output logic [DEPTH_LOG2:0]   level
);

   localparam int                  c_ram_words  = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] c_depth      = (DEPTH_LOG2 + 1)'(2 ** DEPTH_LOG2);
   localparam logic [DEPTH_LOG2:0] c_one        = (DEPTH_LOG2 + 1)'(1);
   localparam logic [15:0]         c_flush_idle = 16'(FLUSH_IDLE);

   // Occupancy never exceeds DEPTH-1 entries because the head lives in
   // r_out_data; the array is sized to the pointer range so wrap is free.
   logic [7:0]            r_ram [0:c_ram_words-1];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [7:0]            r_out_data;
   logic                  r_out_valid;
   logic                  r_in_ready;
   logic [DEPTH_LOG2:0]   r_level;
   logic                  r_flush_n;
   logic                  r_pending;
   logic [15:0]           r_idle_cnt;

   logic                  w_accept;
   logic                  w_consume;
   logic                  w_ram_empty;
   logic                  w_load_head;
   logic                  w_bypass;
   logic                  w_ram_wr;
   logic                  w_ram_rd;
   logic [DEPTH_LOG2:0]   w_level_nxt;

   assign w_accept    = in_valid & r_in_ready;
   assign w_consume   = r_out_valid & out_ready;
   assign w_ram_empty = (r_level <= c_one);
   assign w_load_head = ~r_out_valid | w_consume;
   assign w_bypass    = w_accept & w_load_head & w_ram_empty;
   assign w_ram_wr    = w_accept & ~w_bypass;
   assign w_ram_rd    = w_consume & ~w_ram_empty;

   always_comb begin
      w_level_nxt = r_level;
      if (w_accept && !w_consume) begin
         w_level_nxt = r_level + c_one;
      end else if (!w_accept && w_consume) begin
         w_level_nxt = r_level - c_one;
      end
   end

   always_ff @(posedge clock_60mhz) begin
      if (w_ram_wr) begin
         r_ram[r_wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clock_60mhz or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_out_data  <= 8'h00;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b0;
         r_level     <= '0;
      end else begin
         r_level    <= w_level_nxt;
         r_in_ready <= (w_level_nxt != c_depth);
         if (w_ram_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_ram_rd) begin
            r_out_data  <= r_ram[r_rd_ptr];
            r_out_valid <= 1'b1;
            r_rd_ptr    <= r_rd_ptr + 1'b1;
         end else if (w_bypass) begin
            r_out_data  <= in_data;
            r_out_valid <= 1'b1;
         end else if (w_consume) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   // An accept in the cycle the counter sits at FLUSH_IDLE beats the flush and
   // leaves pending set, so the following drain still earns its own flush.
   always_ff @(posedge clock_60mhz or negedge reset_n) begin
      if (!reset_n) begin
         r_flush_n  <= 1'b1;
         r_pending  <= 1'b0;
         r_idle_cnt <= '0;
      end else begin
         r_flush_n <= 1'b1;
         if (w_accept || (r_level != '0)) begin
            r_idle_cnt <= '0;
         end else if (r_pending && (r_idle_cnt == c_flush_idle)) begin
            r_flush_n  <= 1'b0;
            r_pending  <= 1'b0;
            r_idle_cnt <= '0;
         end else if (r_pending && (r_idle_cnt < c_flush_idle)) begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
         end
         if (w_consume) begin
            r_pending <= 1'b1;
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign flush_n   = r_flush_n;
   assign level     = r_level;

endmodule

`default_nettype wire

// File: tb/tb_ft245_tx_buffer.sv
// ============================================================================
// Module      : tb_ft245_tx_buffer
// Description : Self-checking bench for ft245_tx_buffer against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ft245_tx_buffer;

   localparam int c_flush = 4;
   localparam int c_depth = 16;

   logic       clock_60mhz;
   logic       reset_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       flush_n;
   logic [4:0] level;

   int checks;
   int errors;

   // Reference model: a byte queue plus the idle-flush bookkeeping.
   logic [7:0] m_q[$];
   logic       m_in_ready;
   logic       m_pending;
   logic       m_flush_n;
   int         m_cnt;

   ft245_tx_buffer #(.DEPTH_LOG2(4), .FLUSH_IDLE(c_flush)) dut (
      .clock_60mhz (clock_60mhz),
      .reset_n     (reset_n),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .flush_n     (flush_n),
      .level       (level)
   );

   initial begin
      clock_60mhz = 1'b0;
      forever #5 clock_60mhz = ~clock_60mhz;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      m_q.delete();
      m_in_ready = 1'b0;
      m_pending  = 1'b0;
      m_flush_n  = 1'b1;
      m_cnt      = 0;
   endtask

   task automatic model_step();
      bit acc;
      bit con;
      int lvl;
      acc = in_valid && m_in_ready;
      con = out_ready && (m_q.size() > 0);
      lvl = m_q.size();
      m_flush_n = 1'b1;
      if (acc || lvl != 0) m_cnt = 0;
      else if (m_pending && m_cnt == c_flush) begin
         m_flush_n = 1'b0;
         m_pending = 1'b0;
         m_cnt     = 0;
      end else if (m_pending) m_cnt++;
      if (con) begin
         m_pending = 1'b1;
         void'(m_q.pop_front());
      end
      if (acc) m_q.push_back(in_data);
      m_in_ready = (m_q.size() < c_depth);
   endtask

   task automatic tick();
      @(posedge clock_60mhz);
      if (reset_n) model_step();
      #1;
   endtask

   task automatic drain_idle(input int idle);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 40 && m_q.size() > 0; i++) tick();
      out_ready = 1'b0;
      repeat (idle) tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
      #1 reset_n = 1'b0;
      #2;
      model_reset();
      checks++;
      if ({in_ready, out_valid, flush_n, level, out_data} !== {1'b0, 1'b0, 1'b1, 5'd0, 8'h00}) begin
         errors++;
         $display("FAIL reset_values got rdy=%b vld=%b fl=%b lvl=%0d data=%h want 0 0 1 0 00",
                  in_ready, out_valid, flush_n, level, out_data);
      end
      repeat (2) tick();
      reset_n = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL ready_before_edge got %b want 0", in_ready);
      end
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL ready_first_edge got rdy=%b vld=%b want 1 0", in_ready, out_valid);
      end
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({out_valid, out_data, level, in_ready} !== {1'b1, 8'hA5, 5'd1, 1'b1}) begin
            errors++;
            $display("FAIL first_byte cyc %0d got vld=%b data=%h lvl=%0d rdy=%b want 1 a5 1 1",
                     i, out_valid, out_data, level, in_ready);
         end
         tick();
      end
   endtask

   task automatic test_fill();
      drain_idle(10);
      checks++;
      if (level !== 5'd0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL fill_pre got lvl=%0d vld=%b want 0 0", level, out_valid);
      end
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1; in_data = 8'(i);
         tick();
         checks++;
         if (level !== 5'(i + 1) || in_ready !== (i < 15)) begin
            errors++;
            $display("FAIL fill_level i=%0d got lvl=%0d rdy=%b want %0d %b", i, level, in_ready, i + 1, i < 15);
         end
      end
      in_data = 8'h10;
      repeat (3) tick();
      checks++;
      if (level !== 5'd16 || in_ready !== 1'b0 || out_data !== 8'h00) begin
         errors++;
         $display("FAIL fill_full got lvl=%0d rdy=%b data=%h want 16 0 00", level, in_ready, out_data);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
            errors++;
            $display("FAIL drain_order i=%0d got vld=%b data=%h want 1 %h", i, out_valid, out_data, 8'(i));
         end
         tick();
      end
      out_ready = 1'b0;
      checks++;
      if (level !== 5'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL drain_end got lvl=%0d vld=%b rdy=%b want 0 0 1", level, out_valid, in_ready);
      end
   endtask

   task automatic test_stream();
      logic [7:0] got[$];
      int sent;
      int bad;
      sent = 0;
      drain_idle(10);
      for (int cyc = 0; cyc < 2000 && got.size() < 100; cyc++) begin
         in_valid  = (sent < 100);
         in_data   = 8'(sent);
         out_ready = 1'($urandom_range(0, 1));
         if (out_valid && out_ready) got.push_back(out_data);
         if (in_valid && m_in_ready) sent++;
         tick();
         checks++;
         if ({in_ready, out_valid, flush_n, level} !== {m_in_ready, m_q.size() != 0, m_flush_n, 5'(m_q.size())}
             || (m_q.size() != 0 && out_data !== m_q[0]) || level > 5'd16) begin
            errors++;
            $display("FAIL stream_state cyc %0d got rdy=%b vld=%b fl=%b lvl=%0d data=%h want %b %b %b %0d",
                     cyc, in_ready, out_valid, flush_n, level, out_data,
                     m_in_ready, m_q.size() != 0, m_flush_n, m_q.size());
         end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      bad = -1;
      for (int i = 0; i < got.size(); i++) if (bad < 0 && got[i] !== 8'(i)) bad = i;
      checks++;
      if (got.size() != 100 || bad >= 0) begin
         errors++;
         $display("FAIL stream_sequence got %0d bytes first_bad=%0d want 100 bytes 0..99 in order", got.size(), bad);
      end
   endtask

   task automatic test_back_to_back();
      int cons;
      drain_idle(10);
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_data = 8'($urandom);
         tick();
      end
      cons = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_data = 8'($urandom);
         if (out_valid && out_ready) cons++;
         tick();
         checks++;
         if (level !== 5'd8 || out_valid !== 1'b1 || out_data !== m_q[0]) begin
            errors++;
            $display("FAIL b2b_level8 i=%0d got lvl=%0d vld=%b data=%h want 8 1 %h", i, level, out_valid, out_data, m_q[0]);
         end
      end
      checks++;
      if (cons != 20) begin
         errors++; $display("FAIL b2b_throughput got %0d consumes want 20", cons);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 20 && m_q.size() > 1; i++) tick();
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = 8'($urandom);
         tick();
         checks++;
         if (level !== 5'd1 || out_valid !== 1'b1 || out_data !== m_q[0]) begin
            errors++;
            $display("FAIL b2b_level1 i=%0d got lvl=%0d vld=%b data=%h want 1 1 %h", i, level, out_valid, out_data, m_q[0]);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_flush();
      int nflush;
      int at;
      drain_idle(12);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 8'($urandom);
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 10 && m_q.size() > 0; i++) tick();
      out_ready = 1'b0;
      nflush = 0; at = -1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (flush_n === 1'b0) begin nflush++; at = k; end
         checks++;
         if (flush_n !== m_flush_n || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle k=%0d got fl=%b vld=%b want %b 0", k, flush_n, out_valid, m_flush_n);
         end
      end
      checks++;
      if (nflush != 1 || at != c_flush + 1) begin
         errors++;
         $display("FAIL flush_once got %0d pulses at %0d want 1 at %0d", nflush, at, c_flush + 1);
      end
      in_valid = 1'b1; in_data = 8'h3C;
      tick();
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      nflush = 0;
      repeat (c_flush) begin
         tick();
         if (flush_n === 1'b0) nflush++;
      end
      in_valid = 1'b1; in_data = 8'h5A;
      tick();
      if (flush_n === 1'b0) nflush++;
      checks++;
      if (nflush != 0 || level !== 5'd1) begin
         errors++;
         $display("FAIL flush_suppress got %0d pulses lvl=%0d want 0 pulses lvl 1", nflush, level);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      nflush = 0;
      repeat (12) begin
         tick();
         if (flush_n === 1'b0) nflush++;
         checks++;
         if (flush_n !== m_flush_n) begin
            errors++; $display("FAIL flush_after_suppress got fl=%b want %b", flush_n, m_flush_n);
         end
      end
      checks++;
      if (nflush != 1) begin
         errors++; $display("FAIL flush_pending_kept got %0d pulses want 1", nflush);
      end
   endtask

   task automatic test_reset_mid();
      drain_idle(2);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_data = 8'($urandom);
         tick();
      end
      checks++;
      if (level !== 5'd10) begin
         errors++; $display("FAIL mid_prefill got lvl=%0d want 10", level);
      end
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if ({out_valid, in_ready, level, flush_n} !== {1'b0, 1'b0, 5'd0, 1'b1}) begin
         errors++;
         $display("FAIL mid_async_reset got vld=%b rdy=%b lvl=%0d fl=%b want 0 0 0 1", out_valid, in_ready, level, flush_n);
      end
      repeat (2) tick();
      reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b0 || flush_n !== 1'b1 || level !== 5'd0 || in_ready !== m_in_ready) begin
            errors++;
            $display("FAIL mid_after_release i=%0d got vld=%b fl=%b lvl=%0d rdy=%b want 0 1 0 %b",
                     i, out_valid, flush_n, level, in_ready, m_in_ready);
         end
      end
      out_ready = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      model_reset();
      test_reset();
      test_fill();
      test_stream();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
